// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Shares the push port of one DEPTH-entry FIFO between NREQ requesters.
//   Round-robin arbitration with bursts of up to BURST consecutive grants
//   to a requester that keeps requesting. A local occupancy count keeps the
//   arbiter from pushing into a full FIFO and filters pops on an empty one.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   req        per-requester push request
//   data_in    requester data, slice i = data_in[i*WIDTH +: WIDTH]
//   gnt        one-hot grant (combinational, same cycle as the request)
//   fifo_push  push strobe to the FIFO (= |gnt)
//   fifo_data  data of the granted requester, 0 when nothing is granted
//   pop        downstream pop request
//   fifo_pop   qualified pop (pop while not empty)
//   full       cnt == DEPTH
//   empty      cnt == 0
//   cnt        registered occupancy
module fifo_push_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int CNTWID = $clog2(DEPTH) + 1,
  parameter int BURST  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data_in,
  output logic [NREQ-1:0]         gnt,
  output logic                    fifo_push,
  output logic [WIDTH-1:0]        fifo_data,
  input  logic                    pop,
  output logic                    fifo_pop,
  output logic                    full,
  output logic                    empty,
  output logic [CNTWID-1:0]       cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_reg;
  logic [PW-1:0]       ptr_reg;
  logic [PW-1:0]       owner_reg;
  logic [BW-1:0]       bcnt_reg;
  logic [CNTWID-1:0]   cnt_reg;

  logic [PW-1:0]       pick;
  logic                pick_valid;
  logic [WIDTH-1:0]    masked [NREQ];

  // Pointer advance with wrap, valid for any NREQ (not only powers of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] x);
    return (x == PW'(NREQ - 1)) ? '0 : x + PW'(1);
  endfunction

  // Index k positions after base, modulo NREQ.
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  assign full     = (cnt_reg == CNTWID'(DEPTH));
  assign empty    = (cnt_reg == '0);
  assign cnt      = cnt_reg;
  assign fifo_pop = pop & ~empty & ~rst;

  // First requester at or after ptr, wrapping.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_valid && req[rr_idx(ptr_reg, k)]) begin
        pick       = rr_idx(ptr_reg, k);
        pick_valid = 1'b1;
      end
    end
  end

  // In HOLD only the owner may be granted; a dropped owner request yields
  // an empty cycle while the pointer moves on.
  always_comb begin
    gnt = '0;
    if (!rst && !full) begin
      if (state_reg == IDLE) begin
        if (pick_valid) gnt[pick] = 1'b1;
      end else if (req[owner_reg]) begin
        gnt[owner_reg] = 1'b1;
      end
    end
  end

  assign fifo_push = |gnt;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
    assign masked[gi] = gnt[gi] ? data_in[gi*WIDTH +: WIDTH] : '0;
  end

  // One-hot grant makes an OR-reduction of the masked slices a clean mux.
  always_comb begin
    fifo_data = '0;
    for (int k = 0; k < NREQ; k++) fifo_data = fifo_data | masked[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      bcnt_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      // Push is never issued when full and pop is gated when empty,
      // so this cannot overflow or underflow.
      cnt_reg <= cnt_reg + CNTWID'(fifo_push) - CNTWID'(fifo_pop);
      case (state_reg)
        IDLE: begin
          if (fifo_push) begin
            if (BURST > 1) begin
              state_reg <= HOLD;
              owner_reg <= pick;
              bcnt_reg  <= BW'(1);
            end else begin
              ptr_reg <= ptr_inc(pick);
            end
          end
        end
        HOLD: begin
          if (!req[owner_reg]) begin
            ptr_reg   <= ptr_inc(owner_reg);
            state_reg <= IDLE;
            bcnt_reg  <= '0;
          end else if (fifo_push) begin
            if (bcnt_reg + BW'(1) == BW'(BURST)) begin
              ptr_reg   <= ptr_inc(owner_reg);
              state_reg <= IDLE;
              bcnt_reg  <= '0;
            end else begin
              bcnt_reg <= bcnt_reg + BW'(1);
            end
          end
          // full with owner still requesting: hold, bcnt unchanged
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Testbench for fifo_push_arbiter (NREQ=4, WIDTH=8, DEPTH=8, BURST=2).
// Each scenario task walks a stimulus table; per cycle the expected outputs
// are pushed to a scoreboard queue when the inputs are driven and popped and
// compared at the following negedge.
module tb_fifo_push_arbiter;
  localparam int NREQ   = 4;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 8;
  localparam int CNTWID = 4;
  localparam int BURST  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_push;
  logic [WIDTH-1:0]      fifo_data;
  logic                  pop;
  logic                  fifo_pop;
  logic                  full;
  logic                  empty;
  logic [CNTWID-1:0]     cnt;

  fifo_push_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNTWID(CNTWID), .BURST(BURST)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .gnt(gnt),
    .fifo_push(fifo_push), .fifo_data(fifo_data), .pop(pop),
    .fifo_pop(fifo_pop), .full(full), .empty(empty), .cnt(cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] dvals [NREQ];

  typedef struct {
    logic [NREQ-1:0]   gnt;
    logic [WIDTH-1:0]  data;
    logic              fpop;
    logic [CNTWID-1:0] cnt;
  } exp_t;

  // r: rst, rq: req, p: pop, g: expected grant index (-1 none),
  // ep: expected fifo_pop, c: expected cnt seen in that cycle
  typedef struct {
    logic            r;
    logic [NREQ-1:0] rq;
    logic            p;
    int              g;
    logic            ep;
    int              c;
  } step_t;

  exp_t sb[$];

  function automatic exp_t mk(input int g, input logic p, input int c);
    exp_t e;
    logic [NREQ-1:0] one;
    one    = 1;
    e.gnt  = (g < 0) ? '0 : (one << g);
    e.data = (g < 0) ? '0 : dvals[g];
    e.fpop = p;
    e.cnt  = CNTWID'(c);
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic new_data();
    for (int i = 0; i < NREQ; i++) begin
      dvals[i] = WIDTH'($urandom_range(1, 255));
      data_in[i*WIDTH +: WIDTH] = dvals[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; pop = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step_t st [5] = '{
      '{1'b1, 4'b1111, 1'b1, -1, 1'b0, 0},
      '{1'b1, 4'b1111, 1'b1, -1, 1'b0, 0},
      '{1'b0, 4'b0000, 1'b1, -1, 1'b0, 0},
      '{1'b0, 4'b0000, 1'b1, -1, 1'b0, 0},
      '{1'b0, 4'b0000, 1'b1, -1, 1'b0, 0}};
    exp_t e;
    new_data();
    rst = 1'b1; req = '1; pop = 1'b1;
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      rst = st[k].r; req = st[k].rq; pop = st[k].p;
      sb.push_back(mk(st[k].g, st[k].ep, st[k].c));
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({gnt, fifo_push, fifo_data, fifo_pop, cnt, full, empty} !==
          {e.gnt, |e.gnt, e.data, e.fpop, e.cnt, e.cnt == CNTWID'(DEPTH), e.cnt == '0}) begin
        bad++;
        $display("FAIL reset[%0d]: got gnt=%b push=%b data=%h pop=%b cnt=%0d full=%b empty=%b, want gnt=%b data=%h pop=%b cnt=%0d",
                 k, gnt, fifo_push, fifo_data, fifo_pop, cnt, full, empty, e.gnt, e.data, e.fpop, e.cnt);
      end else
        $display("ok reset[%0d]: gnt=%b data=%h pop=%b cnt=%0d", k, gnt, fifo_data, fifo_pop, cnt);
      next_cycle();
    end
  endtask

  task automatic test_fairness();
    int seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    exp_t e;
    do_reset();
    new_data();
    for (int k = 0; k < 9; k++) begin
      req = '1; pop = 1'b1;
      sb.push_back(mk(seq[k], k > 0, (k > 0) ? 1 : 0));
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({gnt, fifo_push, fifo_data, fifo_pop, cnt, full, empty} !==
          {e.gnt, |e.gnt, e.data, e.fpop, e.cnt, e.cnt == CNTWID'(DEPTH), e.cnt == '0}) begin
        bad++;
        $display("FAIL fairness[%0d]: got gnt=%b push=%b data=%h pop=%b cnt=%0d full=%b empty=%b, want gnt=%b data=%h pop=%b cnt=%0d",
                 k, gnt, fifo_push, fifo_data, fifo_pop, cnt, full, empty, e.gnt, e.data, e.fpop, e.cnt);
      end else
        $display("ok fairness[%0d]: gnt=%b data=%h pop=%b cnt=%0d", k, gnt, fifo_data, fifo_pop, cnt);
      next_cycle();
    end
  endtask

  task automatic test_fill();
    step_t st [12];
    exp_t e;
    for (int k = 0; k < 8; k++) st[k] = '{1'b0, 4'b0100, 1'b0, 2, 1'b0, k};
    st[8]  = '{1'b0, 4'b0100, 1'b0, -1, 1'b0, 8};  // full blocks grant
    st[9]  = '{1'b0, 4'b0100, 1'b1, -1, 1'b1, 8};  // pop while full: no bypass
    st[10] = '{1'b0, 4'b0100, 1'b0,  2, 1'b0, 7};  // room again: grant resumes
    st[11] = '{1'b0, 4'b0100, 1'b0, -1, 1'b0, 8};
    do_reset();
    new_data();
    for (int k = 0; k < 12; k++) begin
      rst = st[k].r; req = st[k].rq; pop = st[k].p;
      sb.push_back(mk(st[k].g, st[k].ep, st[k].c));
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({gnt, fifo_push, fifo_data, fifo_pop, cnt, full, empty} !==
          {e.gnt, |e.gnt, e.data, e.fpop, e.cnt, e.cnt == CNTWID'(DEPTH), e.cnt == '0}) begin
        bad++;
        $display("FAIL fill[%0d]: got gnt=%b push=%b data=%h pop=%b cnt=%0d full=%b empty=%b, want gnt=%b data=%h pop=%b cnt=%0d",
                 k, gnt, fifo_push, fifo_data, fifo_pop, cnt, full, empty, e.gnt, e.data, e.fpop, e.cnt);
      end else
        $display("ok fill[%0d]: gnt=%b data=%h pop=%b cnt=%0d", k, gnt, fifo_data, fifo_pop, cnt);
      next_cycle();
    end
  endtask

  task automatic test_burst_abort();
    // Owner 1 drops while others request: empty cycle, then ptr=2 picks 3.
    step_t st [4] = '{
      '{1'b0, 4'b0010, 1'b0,  1, 1'b0, 0},
      '{1'b0, 4'b1001, 1'b0, -1, 1'b0, 1},
      '{1'b0, 4'b1011, 1'b0,  3, 1'b0, 1},
      '{1'b0, 4'b0000, 1'b1, -1, 1'b1, 2}};
    exp_t e;
    do_reset();
    new_data();
    for (int k = 0; k < 4; k++) begin
      rst = st[k].r; req = st[k].rq; pop = st[k].p;
      sb.push_back(mk(st[k].g, st[k].ep, st[k].c));
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({gnt, fifo_push, fifo_data, fifo_pop, cnt, full, empty} !==
          {e.gnt, |e.gnt, e.data, e.fpop, e.cnt, e.cnt == CNTWID'(DEPTH), e.cnt == '0}) begin
        bad++;
        $display("FAIL abort[%0d]: got gnt=%b push=%b data=%h pop=%b cnt=%0d full=%b empty=%b, want gnt=%b data=%h pop=%b cnt=%0d",
                 k, gnt, fifo_push, fifo_data, fifo_pop, cnt, full, empty, e.gnt, e.data, e.fpop, e.cnt);
      end else
        $display("ok abort[%0d]: gnt=%b data=%h pop=%b cnt=%0d", k, gnt, fifo_data, fifo_pop, cnt);
      next_cycle();
    end
  endtask

  task automatic test_simul_push_pop();
    step_t st [5] = '{
      '{1'b0, 4'b0001, 1'b0,  0, 1'b0, 0},
      '{1'b0, 4'b0001, 1'b0,  0, 1'b0, 1},
      '{1'b0, 4'b0001, 1'b0,  0, 1'b0, 2},
      '{1'b0, 4'b0001, 1'b1,  0, 1'b1, 3},
      '{1'b0, 4'b0000, 1'b0, -1, 1'b0, 3}};
    exp_t e;
    do_reset();
    new_data();
    for (int k = 0; k < 5; k++) begin
      rst = st[k].r; req = st[k].rq; pop = st[k].p;
      sb.push_back(mk(st[k].g, st[k].ep, st[k].c));
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({gnt, fifo_push, fifo_data, fifo_pop, cnt, full, empty} !==
          {e.gnt, |e.gnt, e.data, e.fpop, e.cnt, e.cnt == CNTWID'(DEPTH), e.cnt == '0}) begin
        bad++;
        $display("FAIL simul[%0d]: got gnt=%b push=%b data=%h pop=%b cnt=%0d full=%b empty=%b, want gnt=%b data=%h pop=%b cnt=%0d",
                 k, gnt, fifo_push, fifo_data, fifo_pop, cnt, full, empty, e.gnt, e.data, e.fpop, e.cnt);
      end else
        $display("ok simul[%0d]: gnt=%b data=%h pop=%b cnt=%0d", k, gnt, fifo_data, fifo_pop, cnt);
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_hold();
    step_t st [8];
    exp_t e;
    for (int k = 0; k < 5; k++) st[k] = '{1'b0, 4'b0100, 1'b0, 2, 1'b0, k};
    st[5] = '{1'b1, 4'b0100, 1'b1, -1, 1'b0, 5};  // reset cycle: no grant, no pop
    st[6] = '{1'b0, 4'b1010, 1'b0,  1, 1'b0, 0};  // IDLE with ptr=0 picks 1
    st[7] = '{1'b0, 4'b0000, 1'b0, -1, 1'b0, 1};
    do_reset();
    new_data();
    for (int k = 0; k < 8; k++) begin
      rst = st[k].r; req = st[k].rq; pop = st[k].p;
      sb.push_back(mk(st[k].g, st[k].ep, st[k].c));
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({gnt, fifo_push, fifo_data, fifo_pop, cnt, full, empty} !==
          {e.gnt, |e.gnt, e.data, e.fpop, e.cnt, e.cnt == CNTWID'(DEPTH), e.cnt == '0}) begin
        bad++;
        $display("FAIL midreset[%0d]: got gnt=%b push=%b data=%h pop=%b cnt=%0d full=%b empty=%b, want gnt=%b data=%h pop=%b cnt=%0d",
                 k, gnt, fifo_push, fifo_data, fifo_pop, cnt, full, empty, e.gnt, e.data, e.fpop, e.cnt);
      end else
        $display("ok midreset[%0d]: gnt=%b data=%h pop=%b cnt=%0d", k, gnt, fifo_data, fifo_pop, cnt);
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; pop = 1'b0; data_in = '0;
    test_reset();
    test_fairness();
    test_fill();
    test_burst_abort();
    test_simul_push_pop();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
